// File: rtl/fft_mag_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// fft_mag_scan_ctrl_if
//
// This interface bundles every non-clock signal of fft_mag_scan_ctrl. The
// "master" modport is the sequencer's view. The "slave" modport is the view of
// the environment: the system controller, the FFT buffer RAM, the magnitude
// estimator and the detection logic.
//
// Handshake semantics:
//   start      - Frame request level. It is sampled only while the sequencer
//                is idle (busy=0, done=0). At any other time it is ignored and
//                nothing is queued.
//   busy       - High from the first RAM read through the last pipeline flush
//                cycle.
//   done       - One-cycle pulse in the cycle after busy falls. peak_idx and
//                peak_mag are final from this pulse until the next accepted
//                start.
//   ram_rd     - Read strobe for the FFT buffer. ram_re/ram_im must present
//                bin ram_addr on the following cycle.
//   mag_en     - Qualifies mag_re/mag_im. The estimator returns its registered
//                result on mag_in on the following cycle.
//   bin_valid  - Qualifies bin_idx/bin_mag. There is no backpressure: the
//                consumer must take one word per cycle.
//
// Signal summary (widths):
//   start, busy, done, ram_rd, mag_en, bin_valid : 1
//   ram_addr, bin_idx, peak_idx                  : AW
//   ram_re, ram_im, mag_re, mag_im               : 40 (two's complement)
//   mag_in, bin_mag, peak_mag                    : 41 (unsigned)
// ----------------------------------------------------------------------------
interface fft_mag_scan_ctrl_if #(
    parameter int AW = 6
);
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [39:0]   ram_re;
    logic [39:0]   ram_im;
    logic [39:0]   mag_re;
    logic [39:0]   mag_im;
    logic          mag_en;
    logic [40:0]   mag_in;
    logic          bin_valid;
    logic [AW-1:0] bin_idx;
    logic [40:0]   bin_mag;
    logic [AW-1:0] peak_idx;
    logic [40:0]   peak_mag;

    modport master (
        input  start, ram_re, ram_im, mag_in,
        output busy, done, ram_rd, ram_addr, mag_re, mag_im, mag_en,
               bin_valid, bin_idx, bin_mag, peak_idx, peak_mag
    );

    modport slave (
        output start, ram_re, ram_im, mag_in,
        input  busy, done, ram_rd, ram_addr, mag_re, mag_im, mag_en,
               bin_valid, bin_idx, bin_mag, peak_idx, peak_mag
    );
endinterface

// File: rtl/fft_mag_scan_ctrl.sv
// ----------------------------------------------------------------------------
// fft_mag_scan_ctrl
//
// This block sweeps one FFT frame out of the FFT output buffer RAM. Each bin
// pair is fed to the external magnitude estimator. The block then streams the
// per-bin magnitudes and records the peak bin of the frame.
//
// Ports:
//   clk         - System clock, rising edge.
//   reset       - Synchronous, active-high reset. It forces IDLE and drops all
//                 pipeline valids. A frame in progress is discarded.
//   io_bus      - fft_mag_scan_ctrl_if.master. It carries the start/busy/done
//                 handshake, the RAM read port, the estimator port, the bin
//                 stream and the peak result.
//   o_dbg_state - Current FSM state, encoded as:
//                 0 = IDLE, 1 = RUN, 2 = DRAIN, 3 = DONE.
//
// Parameters:
//   NPOINT - Number of bins per frame. It must be a power of two in the range
//            4..4096.
//   AW     - Bin index width. It must equal log2(NPOINT).
//
// Build option:
//   PEAK_SKIP_DC_EN - When this macro is defined, bin 0 (the DC bin) is left
//                     out of peak tracking and bin 1 seeds the peak. Bin 0 is
//                     still streamed on bin_valid.
//
// Pipeline, for a start sampled at edge 0:
//   cycles 1..N     RUN    ram_rd, ram_addr = 0..N-1
//   cycles 2..N+1   stage1 mag_en, mag_re/mag_im = ram_re/ram_im
//   cycles 3..N+2   stage2 bin_valid, bin_mag = mag_in
//   cycle  N+3      DONE   done pulse
// ----------------------------------------------------------------------------
module fft_mag_scan_ctrl #(
    parameter int NPOINT = 64,
    parameter int AW     = 6
) (
    input  logic                clk,
    input  logic                reset,
    fft_mag_scan_ctrl_if.master io_bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPOINT - 1);

    // FSM
    state_t        r_state;
    state_t        w_next;
    logic          w_busy;
    logic          w_done;
    logic          w_rd;

    // Read-address counter and the drain-cycle toggle
    logic [AW-1:0] r_addr;
    logic          r_drain;

    // Pipeline: stage 1 (estimator input), stage 2 (bin stream)
    logic          r_s1_valid;
    logic [AW-1:0] r_s1_idx;
    logic          r_s2_valid;
    logic [AW-1:0] r_s2_idx;

    // Peak tracking
    logic [AW-1:0] r_peak_idx;
    logic [40:0]   r_peak_mag;
    logic          w_eligible;
    logic          w_first;
    logic          w_peak_load;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // Leave RUN once the final address has been issued.
                if (r_addr == LAST_ADDR) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // r_drain is 0 in the first drain cycle and 1 in the second.
                if (r_drain) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_rd   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_busy = 1'b1;
                w_rd   = 1'b1;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address counter and drain counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_addr <= '0;
                    end
                end
                S_RUN: begin
                    // The counter wraps to 0 after NPOINT-1. This leaves it
                    // cleared for the next frame.
                    r_addr <= r_addr + AW'(1);
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain <= 1'b0;
        end else begin
            r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline: the bin index travels alongside the data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
        end else begin
            r_s1_valid <= w_rd;
            r_s2_valid <= r_s1_valid;
            if (w_rd) begin
                r_s1_idx <= r_addr;
            end
            if (r_s1_valid) begin
                r_s2_idx <= r_s1_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Peak tracking
    // The first eligible bin seeds the peak unconditionally. This means no
    // clear is needed at start, and a frame of all-zero magnitudes still
    // reports a defined bin. A later bin replaces the peak only if its
    // magnitude is strictly greater, so a tie keeps the lower index.
    // ------------------------------------------------------------------------
`ifdef PEAK_SKIP_DC_EN
    assign w_eligible = (r_s2_idx != '0);
    assign w_first    = (r_s2_idx == AW'(1));
`else
    assign w_eligible = 1'b1;
    assign w_first    = (r_s2_idx == '0);
`endif

    assign w_peak_load = r_s2_valid && w_eligible &&
                         (w_first || (io_bus.mag_in > r_peak_mag));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak_idx <= '0;
            r_peak_mag <= '0;
        end else if (w_peak_load) begin
            r_peak_idx <= r_s2_idx;
            r_peak_mag <= io_bus.mag_in;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.ram_rd    = w_rd;
    assign io_bus.ram_addr  = r_addr;

    // The estimator inputs are passthroughs. They are meaningful only while
    // mag_en is high.
    assign io_bus.mag_re    = io_bus.ram_re;
    assign io_bus.mag_im    = io_bus.ram_im;
    assign io_bus.mag_en    = r_s1_valid;

    // bin_mag is gated so that it reads 0 outside the stream. This keeps it
    // independent of whatever the estimator holds between frames.
    assign io_bus.bin_valid = r_s2_valid;
    assign io_bus.bin_idx   = r_s2_idx;
    assign io_bus.bin_mag   = r_s2_valid ? io_bus.mag_in : 41'd0;

    assign io_bus.peak_idx  = r_peak_idx;
    assign io_bus.peak_mag  = r_peak_mag;

    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_fft_mag_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_mag_scan_ctrl
//
// This is the directed bench for fft_mag_scan_ctrl with NPOINT=64.
//
// Bench models:
//   FFT buffer RAM  - For bin b it returns re = b, plus 0x10_0000 on the tone
//                     bin. It returns im = -b, or 0 on the tone bin.
//   Estimator       - It registers tab[mag_re[AW-1:0]]. Each test loads tab
//                     with the magnitudes for that scenario.
// ----------------------------------------------------------------------------
module tb_fft_mag_scan_ctrl;
    localparam int N  = 64;
    localparam int AW = 6;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fft_mag_scan_ctrl_if #(.AW(AW)) bus ();

    fft_mag_scan_ctrl #(.NPOINT(N), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_bus      (bus),
        .o_dbg_state (dbg_state)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [40:0] tab [N];
    int          tone_bin    = -1;

    // ---------------- environment models ----------------
    function automatic logic [39:0] re_of(input int b);
        logic [39:0] v;
        v = 40'(b);
        if (b == tone_bin) v = v | 40'h00_0010_0000;
        return v;
    endfunction

    function automatic logic [39:0] im_of(input int b);
        if (b == tone_bin) return 40'd0;
        return 40'd0 - 40'(b);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bus.ram_re <= '0;
            bus.ram_im <= '0;
            bus.mag_in <= '0;
        end else begin
            if (bus.ram_rd) begin
                bus.ram_re <= re_of(int'(bus.ram_addr));
                bus.ram_im <= im_of(int'(bus.ram_addr));
            end else begin
                bus.ram_re <= '0;
                bus.ram_im <= '0;
            end
            if (bus.mag_en) bus.mag_in <= tab[bus.mag_re[AW-1:0]];
            else            bus.mag_in <= '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill(input logic [40:0] val);
        for (int i = 0; i < N; i++) tab[i] = val;
    endtask

    // This task runs one frame and checks every cycle against the fixed
    // schedule. Extra start pulses are driven during cycles s_a and s_b,
    // where a value of -1 means none.
    task automatic scan_frame(input int s_a, input int s_b);
        logic [6:0] exp_ctl;
        logic [6:0] obs_ctl;
        logic [1:0] exp_st;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);                       // edge 0: start sampled
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            exp_st  = (k <= N) ? 2'd1 : (k <= N + 2) ? 2'd2 : (k == N + 3) ? 2'd3 : 2'd0;
            exp_ctl = {(k >= 1 && k <= N + 2), (k == N + 3), (k <= N),
                       (k >= 2 && k <= N + 1), (k >= 3 && k <= N + 2), exp_st};
            obs_ctl = {bus.busy, bus.done, bus.ram_rd, bus.mag_en, bus.bin_valid, dbg_state};
            vectors++;
            if (obs_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL ctl cycle %0d: busy/done/rd/en/valid/state got %b want %b", k, obs_ctl, exp_ctl);
            end
            if (k <= N) begin
                vectors++;
                if (bus.ram_addr !== AW'(k - 1)) begin
                    miscompares++;
                    $display("FAIL ram_addr cycle %0d: got %0d want %0d", k, bus.ram_addr, k - 1);
                end
            end
            if (k >= 2 && k <= N + 1) begin
                vectors++;
                if (bus.mag_re !== re_of(k - 2) || bus.mag_im !== im_of(k - 2)) begin
                    miscompares++;
                    $display("FAIL mag_re/im cycle %0d: got %h/%h want %h/%h", k,
                             bus.mag_re, bus.mag_im, re_of(k - 2), im_of(k - 2));
                end
            end
            if (k >= 3 && k <= N + 2) begin
                vectors++;
                if (bus.bin_idx !== AW'(k - 3) || bus.bin_mag !== tab[k - 3]) begin
                    miscompares++;
                    $display("FAIL bin cycle %0d: idx/mag got %0d/%h want %0d/%h", k,
                             bus.bin_idx, bus.bin_mag, k - 3, tab[k - 3]);
                end
            end
            bus.start = (k == s_a || k == s_b);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.ram_rd, bus.mag_en, bus.bin_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {bus.busy, bus.done, bus.ram_rd, bus.mag_en, bus.bin_valid});
        end
        vectors++;
        if (bus.ram_addr !== '0 || bus.bin_idx !== '0 || bus.bin_mag !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr/idx/mag got %0d/%0d/%h want 0/0/0",
                     bus.ram_addr, bus.bin_idx, bus.bin_mag);
        end
        vectors++;
        if (bus.peak_idx !== '0 || bus.peak_mag !== '0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_peak: idx/mag/state got %0d/%h/%0d want 0/0/0",
                     bus.peak_idx, bus.peak_mag, dbg_state);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.ram_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: busy/rd got %b%b want 00", bus.busy, bus.ram_rd);
        end
    endtask

    task automatic test_tone();
        fill(41'h10);
        tab[17]  = 41'h400;
        tone_bin = 17;
        scan_frame(-1, -1);
        tone_bin = -1;
        vectors++;
        if (bus.peak_idx !== 6'd17 || bus.peak_mag !== 41'h400) begin
            miscompares++;
            $display("FAIL tone_peak: got %0d/%h want 17/400", bus.peak_idx, bus.peak_mag);
        end
    endtask

    task automatic test_tie();
        fill(41'h1);
        tab[5]  = 41'h800;
        tab[40] = 41'h800;
        scan_frame(-1, -1);
        vectors++;
        if (bus.peak_idx !== 6'd5 || bus.peak_mag !== 41'h800) begin
            miscompares++;
            $display("FAIL tie_peak: got %0d/%h want 5/800", bus.peak_idx, bus.peak_mag);
        end
    endtask

    task automatic test_dc();
        logic [AW-1:0] e_idx;
        logic [40:0]   e_mag;
        fill(41'h0);
        tab[0] = 41'hFFFF;
        tab[9] = 41'h100;
`ifdef PEAK_SKIP_DC_EN
        e_idx = 6'd9;
        e_mag = 41'h100;
`else
        e_idx = 6'd0;
        e_mag = 41'hFFFF;
`endif
        scan_frame(-1, -1);
        vectors++;
        if (bus.peak_idx !== e_idx || bus.peak_mag !== e_mag) begin
            miscompares++;
            $display("FAIL dc_peak: got %0d/%h want %0d/%h", bus.peak_idx, bus.peak_mag, e_idx, e_mag);
        end
    endtask

    task automatic test_start_ignored();
        fill(41'h20);
        tab[2] = 41'h30;
        // The starts at cycles 10 (RUN) and 67 (DONE) must not disturb the
        // schedule. Cycle 68 must be idle.
        scan_frame(10, N + 3);
        vectors++;
        if (bus.peak_idx !== 6'd2 || bus.peak_mag !== 41'h30) begin
            miscompares++;
            $display("FAIL ignored_peak: got %0d/%h want 2/30", bus.peak_idx, bus.peak_mag);
        end
    endtask

    task automatic test_back_to_back();
        int found;
        fill(41'h20);
        tab[63] = 41'h21;
        scan_frame(-1, N + 4);                // start during cycle 68
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.ram_rd !== 1'b1 || bus.ram_addr !== '0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy/rd/addr got %b/%b/%0d want 1/1/0",
                     bus.busy, bus.ram_rd, bus.ram_addr);
        end
        found = -1;
        for (int j = 1; j <= N + 8; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = j;
                break;
            end
        end
        vectors++;
        if (found != N + 2) begin
            miscompares++;
            $display("FAIL b2b_done_latency: got %0d want %0d", found, N + 2);
        end
        vectors++;
        if (bus.peak_idx !== 6'd63 || bus.peak_mag !== 41'h21) begin
            miscompares++;
            $display("FAIL b2b_peak: got %0d/%h want 63/21", bus.peak_idx, bus.peak_mag);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill(41'h50);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= N + 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 30) begin
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL midreset_pre: busy got %b want 1", bus.busy);
                end
                reset = 1'b1;
            end else if (k == 31) begin
                vectors++;
                if ({bus.busy, bus.ram_rd, bus.mag_en, bus.bin_valid, bus.done} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL midreset_ctl: got %b want 00000",
                             {bus.busy, bus.ram_rd, bus.mag_en, bus.bin_valid, bus.done});
                end
                vectors++;
                if (bus.peak_mag !== '0) begin
                    miscompares++;
                    $display("FAIL midreset_peak: got %h want 0", bus.peak_mag);
                end
                reset = 1'b0;
            end else if (k > 31) begin
                vectors++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_nodone cycle %0d: done/busy got %b%b want 00",
                             k, bus.done, bus.busy);
                end
            end
        end
        fill(41'h50);
        tab[30] = 41'h60;
        scan_frame(-1, -1);
        vectors++;
        if (bus.peak_idx !== 6'd30 || bus.peak_mag !== 41'h60) begin
            miscompares++;
            $display("FAIL midreset_rerun_peak: got %0d/%h want 30/60", bus.peak_idx, bus.peak_mag);
        end
    endtask

    task automatic test_all_zero();
        logic [AW-1:0] e_idx;
        fill(41'h0);
`ifdef PEAK_SKIP_DC_EN
        e_idx = 6'd1;
`else
        e_idx = 6'd0;
`endif
        scan_frame(-1, -1);
        vectors++;
        if (bus.peak_idx !== e_idx || bus.peak_mag !== 41'h0) begin
            miscompares++;
            $display("FAIL zero_peak: got %0d/%h want %0d/0", bus.peak_idx, bus.peak_mag, e_idx);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.start = 1'b0;
        fill(41'h0);
        test_reset();
        test_tone();
        test_tie();
        test_dc();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_all_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
